hilo_muldiv: RTL

HILO_MULDIV -- requirements
Module: hilo_muldiv

---
 rtl/hilo_muldiv.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: sequential signed MULT and DIV, one bit per cycle, with MFHI/MFLO read port.
// Define MULDIV_EARLY_OUT_EN to end MUL once the multiplier magnitude has no more set bits.
module hilo_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IN_MD_1,
    input  logic [31:0] IN_MD_2,
    input  logic [11:0] MD_control,
    input  logic        MD_start,
    output logic        MD_busy,
    output logic        MD_done,
    output logic        DIV_BY_ZERO,
    output logic [31:0] OUT_HI,
    output logic [31:0] OUT_LO,
    output logic [31:0] OUT_MD32
);

    localparam logic [11:0] CTRL_MULT = 12'b000011011000;
    localparam logic [11:0] CTRL_DIV  = 12'b000011011010;
    localparam logic [11:0] CTRL_MFHI = 12'b000011010000;
    localparam logic [11:0] CTRL_MFLO = 12'b000011010010;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        dbz_reg;
    logic [4:0]  count_reg;
    logic [4:0]  last_iter_reg;
    logic        neg_result_reg;
    logic        neg_rem_reg;
    logic [63:0] acc_reg;
    logic [63:0] mcand_reg;
    logic [31:0] mplier_reg;   // multiplier for MUL, divisor for DIV
    logic [31:0] rem_reg;
    logic [31:0] quo_reg;

    function automatic logic [4:0] msb_index(input logic [31:0] v);
        msb_index = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) msb_index = i[4:0];
        end
    endfunction

    logic [31:0] mag_1;
    logic [31:0] mag_2;
    logic [4:0]  mul_last;
    logic [63:0] acc_next;
    logic [63:0] product;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic        fits;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] quo_final;
    logic [31:0] rem_final;
    logic        is_last;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign mag_1 = IN_MD_1[31] ? (~IN_MD_1 + 32'd1) : IN_MD_1;
    assign mag_2 = IN_MD_2[31] ? (~IN_MD_2 + 32'd1) : IN_MD_2;

`ifdef MULDIV_EARLY_OUT_EN
    assign mul_last = msb_index(mag_2);
`else
    assign mul_last = 5'd31;
`endif

    assign acc_next  = acc_reg + (mplier_reg[0] ? mcand_reg : 64'd0);
    assign product   = neg_result_reg ? (~acc_next + 64'd1) : acc_next;

    assign rem_shift = {rem_reg, quo_reg[31]};
    assign fits      = (rem_shift >= {1'b0, mplier_reg});
    assign rem_diff  = rem_shift - {1'b0, mplier_reg};
    assign rem_next  = fits ? rem_diff[31:0] : rem_shift[31:0];
    assign quo_next  = {quo_reg[30:0], fits};
    assign quo_final = neg_result_reg ? (~quo_next + 32'd1) : quo_next;
    assign rem_final = neg_rem_reg ? (~rem_next + 32'd1) : rem_next;

    assign is_last   = (count_reg == last_iter_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            hi_reg         <= 32'd0;
            lo_reg         <= 32'd0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            dbz_reg        <= 1'b0;
            count_reg      <= 5'd0;
            last_iter_reg  <= 5'd0;
            neg_result_reg <= 1'b0;
            neg_rem_reg    <= 1'b0;
            acc_reg        <= 64'd0;
            mcand_reg      <= 64'd0;
            mplier_reg     <= 32'd0;
            rem_reg        <= 32'd0;
            quo_reg        <= 32'd0;
        end else begin
            done_reg <= 1'b0;
            dbz_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (MD_start && MD_control == CTRL_MULT) begin
                        state_reg      <= MUL;
                        busy_reg       <= 1'b1;
                        count_reg      <= 5'd0;
                        last_iter_reg  <= mul_last;
                        neg_result_reg <= IN_MD_1[31] ^ IN_MD_2[31];
                        acc_reg        <= 64'd0;
                        mcand_reg      <= {32'd0, mag_1};
                        mplier_reg     <= mag_2;
                    end else if (MD_start && MD_control == CTRL_DIV) begin
                        if (IN_MD_2 == 32'd0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            dbz_reg   <= 1'b1;
                        end else begin
                            state_reg      <= DIV;
                            busy_reg       <= 1'b1;
                            count_reg      <= 5'd0;
                            last_iter_reg  <= 5'd31;
                            neg_result_reg <= IN_MD_1[31] ^ IN_MD_2[31];
                            neg_rem_reg    <= IN_MD_1[31];
                            rem_reg        <= 32'd0;
                            quo_reg        <= mag_1;
                            mplier_reg     <= mag_2;
                        end
                    end
                end
                MUL: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= {mcand_reg[62:0], 1'b0};
                    mplier_reg <= {1'b0, mplier_reg[31:1]};
                    count_reg  <= count_reg + 5'd1;
                    if (is_last) begin
                        hi_reg    <= product[63:32];
                        lo_reg    <= product[31:0];
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DIV: begin
                    rem_reg   <= rem_next;
                    quo_reg   <= quo_next;
                    count_reg <= count_reg + 5'd1;
                    if (is_last) begin
                        hi_reg    <= rem_final;
                        lo_reg    <= quo_final;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign MD_busy     = busy_reg;
    assign MD_done     = done_reg;
    assign DIV_BY_ZERO = dbz_reg;
    assign OUT_HI      = hi_reg;
    assign OUT_LO      = lo_reg;
    assign OUT_MD32    = (MD_control == CTRL_MFHI) ? hi_reg :
                         (MD_control == CTRL_MFLO) ? lo_reg : 32'd0;

endmodule
